// File: rtl/lif_pkg.sv
// lif_pkg: shared defaults and helpers for the LIF neuron array.
//   LIF_N_NEURONS / LIF_WIDTH / LIF_LEAK_W / LIF_REFRAC_CYCLES : default parameters
//   sat_add : clamps a (LIF_WIDTH+1)-bit unsigned sum to LIF_WIDTH bits
package lif_pkg;

    localparam int LIF_N_NEURONS     = 4;
    localparam int LIF_WIDTH         = 8;
    localparam int LIF_LEAK_W        = 3;
    localparam int LIF_REFRAC_CYCLES = 2;

    function automatic logic [LIF_WIDTH-1:0] sat_add(input logic [LIF_WIDTH:0] sum);
        return sum[LIF_WIDTH] ? '1 : sum[LIF_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/lif_update.sv
// lif_update: combinational single-channel leaky integrate-and-fire datapath.
//   v, current      : present potential and input current of the channel
//   threshold       : firing threshold, 0 disables firing
//   leak_shift      : leak = v >> leak_shift, 0 means no leak
//   rc / rc_next    : refractory counter (only with LIF_REFRACTORY_EN)
//   v_next, fire    : next potential and spike decision
// Macro LIF_REFRACTORY_EN adds the refractory counter ports and behaviour.
module lif_update
    import lif_pkg::*;
#(
    parameter int WIDTH  = LIF_WIDTH,
    parameter int LEAK_W = LIF_LEAK_W
`ifdef LIF_REFRACTORY_EN
    ,
    parameter int REFRAC_CYCLES = LIF_REFRAC_CYCLES,
    parameter int RC_W          = $clog2(REFRAC_CYCLES + 1)
`endif
) (
    input  logic [WIDTH-1:0]  v,
    input  logic [WIDTH-1:0]  current,
    input  logic [WIDTH-1:0]  threshold,
    input  logic [LEAK_W-1:0] leak_shift,
`ifdef LIF_REFRACTORY_EN
    input  logic [RC_W-1:0]   rc,
    output logic [RC_W-1:0]   rc_next,
`endif
    output logic [WIDTH-1:0]  v_next,
    output logic              fire
);

    logic [WIDTH-1:0] leak;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] sat;
    logic             fire_raw;

    // v - leak never underflows since leak <= v; shifts of WIDTH or more yield 0.
    always_comb begin
        leak = (leak_shift == '0) ? '0 : (v >> leak_shift);
        sum  = {1'b0, v} - {1'b0, leak} + {1'b0, current};
    end

    if (WIDTH == LIF_WIDTH) begin : g_sat_pkg
        assign sat = sat_add(sum);
    end else begin : g_sat_local
        assign sat = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
    end

    assign fire_raw = (threshold != '0) && (sat >= threshold);

    always_comb begin
`ifdef LIF_REFRACTORY_EN
        if (rc != '0) begin
            v_next  = '0;
            fire    = 1'b0;
            rc_next = rc - 1'b1;
        end else begin
            v_next  = fire_raw ? '0 : sat;
            fire    = fire_raw;
            rc_next = fire_raw ? RC_W'(REFRAC_CYCLES) : '0;
        end
`else
        v_next = fire_raw ? '0 : sat;
        fire   = fire_raw;
`endif
    end

endmodule

// File: rtl/lif_array.sv
// lif_array: time-multiplexed array of leaky integrate-and-fire neurons.
// One shared lif_update datapath serves the channels round-robin, one per enabled cycle.
//   clk, reset_n  : clock, synchronous active-low reset
//   en            : update channel ptr this cycle
//   current       : per-channel current, channel i at [i*WIDTH +: WIDTH]
//   threshold     : shared firing threshold, 0 disables firing
//   leak_shift    : leak = v >> leak_shift, 0 means no leak
//   state_sel     : channel shown on state
//   state         : registered potential of channel state_sel (0 if out of range)
//   spk           : registered one-cycle spike pulse per channel
//   sweep_done    : registered pulse after the last channel is updated
// Macro LIF_REFRACTORY_EN enables per-channel refractory counters.
module lif_array
    import lif_pkg::*;
#(
    parameter int N_NEURONS     = LIF_N_NEURONS,
    parameter int WIDTH         = LIF_WIDTH,
    parameter int LEAK_W        = LIF_LEAK_W,
    parameter int REFRAC_CYCLES = LIF_REFRAC_CYCLES,
    localparam int IDX_W        = $clog2(N_NEURONS)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       en,
    input  logic [N_NEURONS*WIDTH-1:0] current,
    input  logic [WIDTH-1:0]           threshold,
    input  logic [LEAK_W-1:0]          leak_shift,
    input  logic [IDX_W-1:0]           state_sel,
    output logic [WIDTH-1:0]           state,
    output logic [N_NEURONS-1:0]       spk,
    output logic                       sweep_done
);

    if (N_NEURONS < 2 || REFRAC_CYCLES < 1) begin : g_cfg_check
        $error("lif_array: N_NEURONS must be >= 2 and REFRAC_CYCLES >= 1");
    end

    logic [WIDTH-1:0] v [N_NEURONS];
    logic [IDX_W-1:0] ptr;
    logic [WIDTH-1:0] cur_sel;
    logic [WIDTH-1:0] v_next;
    logic             fire;
    logic [WIDTH-1:0] state_mux;
    logic             last_ch;

`ifdef LIF_REFRACTORY_EN
    localparam int RC_W = $clog2(REFRAC_CYCLES + 1);
    logic [RC_W-1:0] rc [N_NEURONS];
    logic [RC_W-1:0] rc_next;
`endif

    assign cur_sel = current[ptr*WIDTH +: WIDTH];
    assign last_ch = (ptr == IDX_W'(N_NEURONS - 1));

    lif_update #(
        .WIDTH         (WIDTH),
        .LEAK_W        (LEAK_W)
`ifdef LIF_REFRACTORY_EN
        ,
        .REFRAC_CYCLES (REFRAC_CYCLES),
        .RC_W          (RC_W)
`endif
    ) u_update (
        .v          (v[ptr]),
        .current    (cur_sel),
        .threshold  (threshold),
        .leak_shift (leak_shift),
`ifdef LIF_REFRACTORY_EN
        .rc         (rc[ptr]),
        .rc_next    (rc_next),
`endif
        .v_next     (v_next),
        .fire       (fire)
    );

    always_comb begin
        state_mux = '0;
        if (int'(state_sel) < N_NEURONS) begin
            state_mux = v[state_sel];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr        <= '0;
            state      <= '0;
            spk        <= '0;
            sweep_done <= '0;
            for (int unsigned i = 0; i < N_NEURONS; i++) begin
                v[i] <= '0;
`ifdef LIF_REFRACTORY_EN
                rc[i] <= '0;
`endif
            end
        end else begin
            state      <= state_mux;
            spk        <= '0;
            sweep_done <= 1'b0;
            if (en) begin
                v[ptr] <= v_next;
`ifdef LIF_REFRACTORY_EN
                rc[ptr] <= rc_next;
`endif
                spk[ptr]   <= fire;
                sweep_done <= last_ch;
                // Explicit wrap so non-power-of-2 channel counts stay in range.
                ptr <= last_ch ? '0 : ptr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lif_array.sv
module tb_lif_array;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        en;
    logic [31:0] current;
    logic [7:0]  threshold;
    logic [2:0]  leak_shift;
    logic [1:0]  state_sel;
    logic [7:0]  state;
    logic [3:0]  spk;
    logic        sweep_done;

    int tests = 0;
    int fails = 0;

    // reference model: plain integer potentials and round-robin index
    int mv [4];
`ifdef LIF_REFRACTORY_EN
    int mrc [4];
`endif
    int mptr;
    logic [7:0] exp_state;
    logic [3:0] exp_spk;
    logic       exp_sweep;
    int spk_cnt;

    lif_array #(
        .N_NEURONS     (4),
        .WIDTH         (8),
        .LEAK_W        (3),
        .REFRAC_CYCLES (2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .current    (current),
        .threshold  (threshold),
        .leak_shift (leak_shift),
        .state_sel  (state_sel),
        .state      (state),
        .spk        (spk),
        .sweep_done (sweep_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        tests++;
        assert (got === expv) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    // One clock: advance the model at the edge, compare registered outputs 1 time unit later.
    task automatic tick();
        int p, cur, lk, sum;
        bit refr;
        @(posedge clk);
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                mv[i] = 0;
`ifdef LIF_REFRACTORY_EN
                mrc[i] = 0;
`endif
            end
            mptr = 0;
            exp_state = '0;
            exp_spk   = '0;
            exp_sweep = 1'b0;
        end else begin
            exp_state = 8'(mv[state_sel]);
            exp_spk   = '0;
            exp_sweep = 1'b0;
            if (en) begin
                p   = mptr;
                cur = int'(current[p*8 +: 8]);
`ifdef LIF_REFRACTORY_EN
                refr = (mrc[p] != 0);
`else
                refr = 1'b0;
`endif
                if (refr) begin
                    mv[p] = 0;
`ifdef LIF_REFRACTORY_EN
                    mrc[p] = mrc[p] - 1;
`endif
                end else begin
                    lk  = (leak_shift == 0) ? 0 : (mv[p] >> leak_shift);
                    sum = mv[p] - lk + cur;
                    if (sum > 255) sum = 255;
                    if (threshold != 0 && sum >= int'(threshold)) begin
                        mv[p] = 0;
                        exp_spk[p] = 1'b1;
`ifdef LIF_REFRACTORY_EN
                        mrc[p] = 2;
`endif
                    end else begin
                        mv[p] = sum;
                    end
                end
                exp_sweep = (p == 3);
                mptr = (p + 1) % 4;
            end
        end
        #1;
        check("state", 32'(state), 32'(exp_state));
        check("spk", 32'(spk), 32'(exp_spk));
        check("sweep_done", 32'(sweep_done), 32'(exp_sweep));
    endtask

    initial begin
        // 1: reset held with nonzero current
        reset_n = 1'b0; en = 1'b1; current = 32'h40404040;
        threshold = 8'd0; leak_shift = 3'd0; state_sel = 2'd0;
        tick();
        tick();

        // 2: ch0 integrates 64/update to saturation and fires
        reset_n = 1'b1; current = 32'h00000040; threshold = 8'd200;
        spk_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            spk_cnt += int'(spk[0]);
        end
        check("t2_spk0_pulses", 32'(spk_cnt), 32'd1);

        // 3: leak settles ch1 at 20
        reset_n = 1'b0; tick();
        reset_n = 1'b1; current = 32'h00000A00; leak_shift = 3'd1;
        threshold = 8'd255; state_sel = 2'd1;
        for (int i = 0; i < 24; i++) tick();
        check("t3_steady", 32'(state), 32'd20);

        // 4: firing disabled, everything saturates
        current = 32'hFFFFFFFF; threshold = 8'd0; leak_shift = 3'd0;
        for (int i = 0; i < 12; i++) begin
            state_sel = 2'(i);
            tick();
        end
        check("t4_sat", 32'(state), 32'd255);

        // 5: ch2 repeated firing, with or without refractory hold
        reset_n = 1'b0; tick();
        reset_n = 1'b1; current = 32'h00FF0000; threshold = 8'd100; state_sel = 2'd2;
        spk_cnt = 0;
        for (int i = 0; i < 48; i++) begin
            tick();
            spk_cnt += int'(spk[2]);
        end
`ifdef LIF_REFRACTORY_EN
        check("t5_spk2_pulses", 32'(spk_cnt), 32'd4);
`else
        check("t5_spk2_pulses", 32'(spk_cnt), 32'd12);
`endif

        // 6: enable gaps mid-sweep, then reset mid-sweep
        current = 32'h01020304; threshold = 8'd0; state_sel = 2'd3;
        en = 1'b1; tick();
        en = 1'b1; tick();
        en = 1'b0; tick();
        en = 1'b0; tick();
        en = 1'b1; tick();
        tick();
        reset_n = 1'b0; tick();
        reset_n = 1'b1; current = 32'h00000005; state_sel = 2'd0;
        tick();
        tick();
        check("t6_first_ch0", 32'(state), 32'd5);

        // randomized phase
        for (int i = 0; i < 400; i++) begin
            reset_n    = ($urandom_range(0, 49) != 0);
            en         = ($urandom_range(0, 3) != 0);
            current    = $urandom;
            threshold  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            leak_shift = 3'($urandom_range(0, 7));
            state_sel  = 2'($urandom_range(0, 3));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
